// File: rtl/nios2_oci_trace_pkg.sv
// Shared types and default sizes for the Nios II OCI trace capture buffer.
package nios2_oci_trace_pkg;

    localparam int TRACE_DATA_W = 30;
    localparam int TRACE_DEPTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_e;

endpackage

// File: rtl/nios2_oci_trace_ram.sv
// DEPTH x DATA_W trace storage: synchronous write, asynchronous (show-ahead) read.
module nios2_oci_trace_ram #(
    parameter int DATA_W = 30,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nios2_oci_trace_capture.sv
// OCI trace capture: circular buffer filled during a test session, then drained
// through a valid/ready port once the test ends.
module nios2_oci_trace_capture
    import nios2_oci_trace_pkg::*;
#(
    parameter int DATA_W    = TRACE_DATA_W,
    parameter int DEPTH     = TRACE_DEPTH,
    parameter bit WRAP_MODE = 1'b1,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              trace_valid,
    input  logic [DATA_W-1:0] trace_data,
    input  logic              test_ending,
    input  logic              test_has_ended,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  dct_count,
    output logic              overflow,
    output logic              done,
    output logic [1:0]        state
);

    localparam int PTR_W = $clog2(DEPTH);

    trace_state_e      state_q;
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ovf_q;
    logic              full, wr_en, pop;
    logic [DATA_W-1:0] ram_rdata;

    assign full  = (cnt_q == CNT_W'(DEPTH));
    // When full in wrap mode the write pointer sits on the oldest entry, so
    // writing there overwrites it.
    assign wr_en = !reset && !arm && (state_q == ST_CAPTURE) && trace_valid
                   && (!full || WRAP_MODE);
    assign pop   = rd_valid && rd_ready;

    nios2_oci_trace_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (trace_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (arm) begin
            state_q  <= ST_CAPTURE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ST_CAPTURE: begin
                    if (trace_valid) begin
                        if (!full) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            cnt_q    <= cnt_q + 1'b1;
                        end else begin
                            ovf_q <= 1'b1;
                            if (WRAP_MODE) begin
                                wr_ptr_q <= wr_ptr_q + 1'b1;
                                rd_ptr_q <= rd_ptr_q + 1'b1;
                            end
                        end
                    end
                    if (test_ending || test_has_ended) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pop) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                        cnt_q    <= cnt_q - 1'b1;
                    end
                    if ((cnt_q == '0) && test_has_ended) state_q <= ST_DONE;
                end
                default: ;
            endcase
        end
    end

    assign rd_valid  = (state_q == ST_DRAIN) && (cnt_q != '0);
    assign rd_data   = rd_valid ? ram_rdata : '0;
    assign dct_count = cnt_q;
    assign overflow  = ovf_q;
    assign done      = (state_q == ST_DONE);
    assign state     = state_q;

endmodule

// File: doc/nios2_oci_trace_capture.md
# nios2_oci_trace_capture

Parametrised on-chip-instrumentation trace capture buffer for the Nios II debug path. It records `trace_data` words into a circular buffer during a test session and freezes the buffer when the test ends. It then drains the contents through a valid/ready read port. It supersedes the passive OCI test-bench monitor with real capture, count, overflow, and drain behaviour.

## Interface
Parameters:
- `DATA_W`, 30: trace word width.
- `DEPTH`, 16: buffer entries. Must be a power of two and at least 2.
- `WRAP_MODE`, 1: behaviour when the buffer is full. 1 overwrites the oldest entry; 0 drops the new word.
- `CNT_W`: derived localparam, $clog2(DEPTH)+1. Not overridable.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `arm` in 1: single-cycle pulse that clears the buffer and starts capture.
- `trace_valid` in 1: qualifies `trace_data`.
- `trace_data` in DATA_W: trace word.
- `test_ending` in 1: freezes capture and begins drain.
- `test_has_ended` in 1: permits completion once the buffer is empty.
- `rd_ready` in 1: consumer accepts `rd_data`.
- `rd_valid` out 1: `rd_data` holds the oldest entry.
- `rd_data` out DATA_W: oldest entry; 0 whenever `rd_valid` is 0.
- `dct_count` out CNT_W: entries currently held, 0..DEPTH.
- `overflow` out 1: sticky flag; set when a word is overwritten or dropped.
- `done` out 1: high in the DONE state.
- `state` out 2: debug view; IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.

## Operation
- Priority at each edge: `reset` > `arm` > state logic.
- On `reset` (held any number of cycles, including mid-operation): state IDLE, write/read pointers 0, `dct_count` 0, `overflow` 0, `rd_valid` 0, `rd_data` 0, `done` 0. Memory contents are not cleared.
- On `arm` in any state: pointers 0, `dct_count` 0, `overflow` 0, next state CAPTURE. A `trace_valid` in the same cycle as `arm` is discarded.
- IDLE: ignores `trace_valid`, `rd_ready`, and the test inputs.
- CAPTURE, `trace_valid` with `dct_count` < DEPTH: write at the write pointer, advance the write pointer, increment `dct_count`.
- CAPTURE, `trace_valid` with `dct_count` == DEPTH and WRAP_MODE=1: overwrite the oldest entry, advance both pointers, hold the count, set `overflow`.
- CAPTURE, `trace_valid` with `dct_count` == DEPTH and WRAP_MODE=0: drop the word, leave pointers and count unchanged, set `overflow`.
- CAPTURE, `test_ending` or `test_has_ended` high: next state DRAIN. A `trace_valid` in that same cycle is still captured.
- DRAIN: `rd_valid` = (`dct_count` != 0). `rd_data` = mem[read pointer], show-ahead.
- DRAIN pop (`rd_valid` & `rd_ready`): advance the read pointer, decrement `dct_count`. `trace_valid` is ignored in DRAIN.
- DRAIN exit: when registered `dct_count` == 0 and `test_has_ended` == 1, next state DONE. With an empty buffer and `test_has_ended` low, stay in DRAIN with `rd_valid` 0.
- DONE: `done` = 1. Stays in DONE until `arm` or `reset`.
- Pointers are log2(DEPTH) bits and wrap naturally modulo DEPTH. `dct_count` never exceeds DEPTH and never underflows.

## Timing
- Write latency: a word accepted at edge N is readable in DRAIN from N+1.
- `test_ending` sampled at edge N: `state` = DRAIN and `rd_valid` valid in cycle N+1.
- Drain throughput: one word per cycle under continuous `rd_ready`. The next word is presented in the cycle after a pop.
- `done` rises the cycle after the exit condition holds.
- All outputs are registered or decoded from registered state/count. There is no combinational input-to-output path except `rd_data`, which is a memory read at the registered read pointer.

## Structure
- Package `nios2_oci_trace_pkg` holds:
  - the 2-bit state typedef and its IDLE/CAPTURE/DRAIN/DONE encodings;
  - the default DATA_W and DEPTH constants.
- Sub-module `nios2_oci_trace_ram`: DEPTH x DATA_W, one synchronous write port and one asynchronous read port.
- The control FSM, pointers, and counter live in the top module.

## Test plan
- Reset: assert `reset` for 2 cycles with random inputs. Required: `state`=0, `dct_count`=0, `rd_valid`=0, `rd_data`=0, `overflow`=0, `done`=0.
- Basic session: `arm`, write 0x1, 0x2, 0x3, pulse `test_ending`, hold `rd_ready`=1. Required: reads 0x1, 0x2, 0x3 on consecutive cycles, `dct_count` 3→0, `overflow`=0. Then raise `test_has_ended`; required: `done`=1 on the next cycle.
- Wrap: DEPTH=16, WRAP_MODE=1, write values 1..20, then drain. Required: `dct_count`=16, `overflow`=1, drained sequence 5..20.
- Drop: DEPTH=16, WRAP_MODE=0, write values 1..20, then drain. Required: `dct_count`=16, `overflow`=1, drained sequence 1..16.
- Simultaneous events:
  - `trace_valid` with 0xAA in the same cycle as `test_ending`: 0xAA must be captured.
  - `trace_valid` during DRAIN: must be ignored.
  - `arm` during DRAIN with `dct_count`=5: next cycle `dct_count`=0, `state`=CAPTURE.
- Reset mid-drain with `dct_count`=7 and `rd_ready` toggling. Required: next cycle IDLE, `dct_count`=0, `rd_valid`=0. A following `arm` plus two writes must drain exactly those two words.
